freq_counter_tx: RTL

Measures the frequency of an external digital signal by counting its rising edges over a fixed gate window of `clk` cycles. At the end of each window it streams the 32-bit count as a 4-byte packet over the AXI-Stream link to the seven-segment display controller. This is the upstream stage of the display path: the measurement source for the frequency meter.

---
 rtl/freq_counter_tx_if.sv | 19 +
 rtl/freq_counter_tx.sv | 114 +++++++++++
 2 files changed

// File: rtl/freq_counter_tx_if.sv
// AXI-Stream byte link used by the frequency meter display path.
// Carries one byte per handshake plus destination id and packet end.
interface axi_if;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic [7:0] tid;
  logic       tlast;

  modport master (
    output tvalid, tdata, tid, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tid, tlast,
    output tready
  );
endinterface

// File: rtl/freq_counter_tx.sv
// Gated edge counter streaming each 32-bit count as a 4-byte packet.
// Define FREQ_CNT_SATURATE_EN to saturate the count instead of wrapping.
module freq_counter_tx #(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter logic [7:0]  DEST_ID     = 8'hFF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  sig_in,
  output logic  meas_valid,
  output logic  overrun,
  axi_if.master axi
);

  localparam logic IDLE = 1'b0;
  localparam logic SEND = 1'b1;
  localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);

  logic        s1, s2, s3;
  logic        edge_p;
  logic [31:0] gate_cnt;
  logic [31:0] edge_cnt;
  logic [31:0] edge_inc;
  logic [31:0] result;
  logic [31:0] shreg;
  logic        gate_end;
  logic        state;
  logic [1:0]  idx;
  logic        fin;
  logic [7:0]  byte_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      edge_p <= 1'b0;
    end else begin
      s1     <= sig_in;
      s2     <= s1;
      s3     <= s2;
      edge_p <= s2 & ~s3;
    end
  end

  assign gate_end = (gate_cnt == GATE_LAST);

  always_ff @(posedge clk) begin
    if (rst || gate_end) gate_cnt <= '0;
    else                 gate_cnt <= gate_cnt + 32'd1;
  end

`ifdef FREQ_CNT_SATURATE_EN
  assign edge_inc = (&edge_cnt) ? edge_cnt : edge_cnt + 32'd1;
`else
  assign edge_inc = edge_cnt + 32'd1;
`endif

  // an edge in the closing cycle still belongs to the closing window
  assign result = edge_p ? edge_inc : edge_cnt;

  always_ff @(posedge clk) begin
    if (rst || gate_end) edge_cnt <= '0;
    else if (edge_p)     edge_cnt <= edge_inc;
  end

  assign fin = (state == SEND) && axi.tready && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 2'd0;
      shreg   <= '0;
      overrun <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gate_end) begin
            state <= SEND;
            idx   <= 2'd0;
            shreg <= result;
          end
        end
        SEND: begin
          if (gate_end && fin) begin
            shreg <= result;
            idx   <= 2'd0;
          end else begin
            if (axi.tready) idx <= idx + 2'd1;
            if (fin)        state <= IDLE;
            if (gate_end)   overrun <= 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    byte_sel = 8'h00;
    unique case (idx)
      2'd0: byte_sel = shreg[31:24];
      2'd1: byte_sel = shreg[23:16];
      2'd2: byte_sel = shreg[15:8];
      2'd3: byte_sel = shreg[7:0];
    endcase
  end

  assign axi.tvalid = (state == SEND);
  assign axi.tdata  = axi.tvalid ? byte_sel : 8'h00;
  assign axi.tid    = axi.tvalid ? DEST_ID : 8'h00;
  assign axi.tlast  = axi.tvalid && (idx == 2'd3);
  assign meas_valid = gate_end && !rst;

endmodule
